// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream selector (explicit select or round-robin), registered output; STREAM_MUX_ARB_STATS_EN adds per-channel transfer counters
module stream_mux_arb #(
  parameter int WIDTH = 64,
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
`ifdef STREAM_MUX_ARB_STATS_EN
  output logic [N*16-1:0]    xfer_count,
`endif
  input  logic               out_ready
);
  logic [SEL_W-1:0] rr_ptr, rr_g, gnt;
  logic rr_hit, sel_hit, gnt_v, load_en, xfer;
  always_comb begin
    rr_hit = 1'b0;
    rr_g = '0;
    // descending scan so the channel closest to rr_ptr is assigned last and wins
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[(int'(rr_ptr) + k) % N]) begin
        rr_hit = 1'b1;
        rr_g = SEL_W'((int'(rr_ptr) + k) % N);
      end
    end
    sel_hit = (int'(sel) < N) ? in_valid[sel] : 1'b0;
    gnt = mode ? rr_g : sel;
    gnt_v = mode ? rr_hit : sel_hit;
    load_en = !out_valid || out_ready;
    xfer = !reset && load_en && gnt_v;
    in_ready = xfer ? (N'(1) << gnt) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      rr_ptr <= '0;
    end else if (load_en) begin
      out_valid <= gnt_v;
      if (gnt_v) begin
        out_data <= in_data[gnt*WIDTH +: WIDTH];
        out_sel <= gnt;
        if (mode) rr_ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      end
    end
  end
`ifdef STREAM_MUX_ARB_STATS_EN
  genvar i;
  for (i = 0; i < N; i++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (in_ready[i] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign xfer_count[i*16 +: 16] = cnt;
  end
`endif
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed scoreboard bench for stream_mux_arb (N=4, 3-bit select so out-of-range sel is reachable)
module tb_stream_mux_arb;
  localparam int W = 64;
  localparam int N = 4;
  localparam int SW = 3;
  logic clk = 0, reset = 1, mode = 0, out_ready = 0;
  logic [SW-1:0] sel = '0;
  logic [N-1:0] in_valid = '0, in_ready;
  logic [N*W-1:0] in_data;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_sel;
  logic [W-1:0] ch [N];
`ifdef STREAM_MUX_ARB_STATS_EN
  logic [N*16-1:0] xfer_count;
`endif
  int checks = 0, errors = 0;
  logic [W+SW-1:0] q [$];
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) in_data[i*W +: W] = ch[i];
  stream_mux_arb #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel),
`ifdef STREAM_MUX_ARB_STATS_EN
    .xfer_count(xfer_count),
`endif
    .out_ready(out_ready));
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        logic [W+SW-1:0] e;
        e = q.pop_front();
        chk("out_data", out_data, e[W+SW-1:SW]);
        chk("out_sel", W'(out_sel), W'(e[SW-1:0]));
      end
    end
  end
  task automatic step(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v, input logic ordy,
                      input logic [N-1:0] er, input logic push, input logic [SW-1:0] es);
    mode = m; sel = s; in_valid = v; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", W'(in_ready), W'(er));
    if (push) q.push_back({ch[es], es});
    @(posedge clk); #1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) ch[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", W'(in_ready), 0);
    @(posedge clk); #1;
    reset = 0;
    chk("reset_out_valid", W'(out_valid), 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_sel", W'(out_sel), 0);
    ch[0] = 2048; ch[1] = 4096;
    step(0, 0, 4'b0011, 1, 4'b0001, 1, 0);
    step(0, 1, 4'b0011, 1, 4'b0010, 1, 1);
    step(0, 1, 4'b0001, 1, 4'b0000, 0, 0);
    chk("no_grant_out_valid", W'(out_valid), 0);
    step(0, 5, 4'b1111, 1, 4'b0000, 0, 0);
    chk("sel_oob_out_valid", W'(out_valid), 0);
    for (int i = 0; i < N; i++) ch[i] = 1024 * (i + 1);
    step(1, 0, 4'b1111, 1, 4'b0001, 1, 0);
    step(1, 0, 4'b1111, 1, 4'b0010, 1, 1);
    step(1, 0, 4'b1111, 1, 4'b0100, 1, 2);
    step(1, 0, 4'b1111, 1, 4'b1000, 1, 3);
    step(1, 0, 4'b1111, 1, 4'b0001, 1, 0);
    step(1, 0, 4'b1010, 1, 4'b0010, 1, 1);
    step(1, 0, 4'b1010, 1, 4'b1000, 1, 3);
    step(1, 0, 4'b1010, 1, 4'b0010, 1, 1);
    step(1, 0, 4'b1010, 1, 4'b1000, 1, 3);
    ch[2] = 8192;
    step(0, 2, 4'b0100, 1, 4'b0100, 1, 2);
    for (int k = 0; k < 3; k++) begin
      step(k[0], SW'(k), 4'b1100, 0, 4'b0000, 0, 0);
      chk("hold_out_valid", W'(out_valid), 1);
      chk("hold_out_data", out_data, 8192);
    end
    step(0, 3, 4'b1000, 1, 4'b1000, 1, 3);
    chk("refill_out_valid", W'(out_valid), 1);
    chk("refill_out_sel", W'(out_sel), 3);
    step(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
    step(1, 0, 4'b0100, 1, 4'b0100, 1, 2);
    out_ready = 0; reset = 1;
    @(negedge clk);
    chk("in_ready_reset_full", W'(in_ready), 0);
    @(posedge clk); #1;
    q.delete();
    reset = 0;
    chk("midreset_out_valid", W'(out_valid), 0);
    chk("midreset_out_data", out_data, 0);
    step(1, 0, 4'b1111, 1, 4'b0001, 1, 0);
`ifdef STREAM_MUX_ARB_STATS_EN
    mode = 0; sel = 0; in_valid = 4'b0001; out_ready = 1;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      q.push_back({ch[0], SW'(0)});
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("xfer_count_ch0_sat", W'(xfer_count[15:0]), 16'hFFFF);
    chk("xfer_count_ch1", W'(xfer_count[31:16]), 0);
`endif
    step(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
    chk("queue_drained", W'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor to the 64-bit 2:1 datapath mux: N-channel, WIDTH-bit stream selector with valid/ready handshake and one registered output stage.
- Two modes: explicit-select (driven by control, like a classic mux) and round-robin arbitration.
- Sits between producer units (ALU result, load data, PC+4, immediate) and a shared consumer, e.g. the writeback path in the pipelined follow-on to the single-cycle core.

Parameters:
- WIDTH, 64, data width per channel in bits.
- N, 4, number of input channels (2..16).
- SEL_W, $clog2(N), width of select and grant index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select via sel, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_valid  input  N  per-channel data valid.
- in_data  input  N*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; combinational.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset: synchronous on clk when reset=1.
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready is all zeros in every cycle where reset=1.
- Output slot has two states, set by out_valid: EMPTY (0) and FULL (1).
  - load_en = !out_valid || out_ready.
- Grant, computed combinationally each cycle:
  - mode=0: grant = sel if sel<N and in_valid[sel]=1; otherwise no grant.
  - mode=1: grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... wrapping modulo N; no grant if in_valid=0.
- Ready: in_ready[i] = load_en && grant valid && grant==i.
  - At most one in_ready bit is high.
  - in_ready never depends on in_valid of a non-granted channel.
- Transfer on rising edge when load_en and a grant exist:
  - out_data <= in_data[grant], out_sel <= grant, out_valid <= 1.
- load_en with no grant: out_valid <= 0; out_data and out_sel hold their values.
- FULL and out_ready=0: all outputs hold; in_ready all 0 (back-pressure).
- Simultaneous drain and refill (FULL, out_ready=1, grant exists): new data is loaded with no bubble.
- Throughput is 1 transfer/cycle. Latency is 1 cycle from input accept to out_valid.
- rr_ptr update:
  - Becomes (grant+1) mod N on every accepted transfer in mode=1; N-1 wraps to 0.
  - Unchanged in mode=0 and on cycles with no transfer.
- Mode or sel change while FULL does not disturb the held output. The new setting applies to the next load.
- Reset mid-transfer (FULL, out_ready=0) discards the held data; out_valid=0 on the next cycle.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro: STREAM_MUX_ARB_STATS_EN.
- Defined:
  - Adds output port xfer_count (N*16 bits): channel i counter at [i*16 +: 16].
  - Counter increments on each accepted transfer from channel i and saturates at 16'hFFFF.
  - All counters clear to 0 on reset.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset, then mode=0, sel=0, in_valid=4'b0011, ch0=2048, ch1=4096, out_ready=1 -> next cycle out_valid=1, out_data=2048, out_sel=0. Set sel=1 -> next cycle out_data=4096, out_sel=1.
- mode=0, sel=1, in_valid=4'b0001 -> in_ready=0, and out_valid=0 after one cycle. Set sel=5 with N=4 -> no grant, in_ready=0.
- mode=1, in_valid=4'b1111 held, out_ready=1, ch i data=1024*(i+1) -> out_sel sequence 0,1,2,3,0 on consecutive cycles with no bubbles; out_data 1024, 2048, 3072, 4096, 1024.
- mode=1, in_valid=4'b1010 -> grants alternate 1,3,1,3; channels 0 and 2 never get in_ready.
- Back-pressure: load ch2=8192, then hold out_ready=0 for 3 cycles -> out_data stays 8192, out_valid=1, in_ready=0. Raise out_ready with ch3 valid -> ch3 data appears on the next edge with no empty cycle.
- Reset asserted while FULL with out_ready=0 -> out_valid=0, out_data=0, rr_ptr=0. With STREAM_MUX_ARB_STATS_EN defined, 70000 ch0 transfers -> xfer_count[15:0]=16'hFFFF.
